vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Schedules the single-port frame-buffer RAM behind `vga_controller`. It issues one display read per active pixel from the lookahead coordinates supplied by the timing generator. A writer port (CPU or drawing engine) is accepted at any time through a small write FIFO, and its entries drain into the RAM only in cycles with no display fetch. The block registers the fetched pixel onto `RGB`, forcing black during blanking.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `ADDR_W`, 19: RAM address width (needs H_ACTIVE*V_ACTIVE ≤ 2^ADDR_W).
- `PIX_W`, 3: pixel width.
- `FIFO_DEPTH`, 4: write FIFO entries (power of two).
- `clk` in 1: single clock. The block has one clock.
- `reset` in 1: asynchronous, active-high reset.
- `pix_x` in 10: x coordinate that will be on screen 3 cycles later (lookahead).
- `pix_y` in 10: y coordinate that will be on screen 3 cycles later (lookahead).
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: FIFO can accept a write.
- `wr_addr` in ADDR_W: linear pixel address, y*H_ACTIVE+x.
- `wr_data` in PIX_W: pixel value.
- `mem_en` out 1: RAM access strobe (registered).
- `mem_we` out 1: RAM write enable (registered).
- `mem_addr` out ADDR_W: RAM address (registered).
- `mem_wdata` out PIX_W: RAM write data (registered).
- `mem_rdata` in PIX_W: RAM read data, valid the cycle after `mem_en`/`!mem_we`.
- `RGB` out PIX_W: pixel to DAC (registered).
- `frame_start` out 1: one-cycle pulse when the fetch of pixel (0,0) is issued.
- `fifo_level` out log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Fetch window: `w = (pix_x < H_ACTIVE) && (pix_y < V_ACTIVE)`. It is evaluated combinationally each cycle.
- FSM states are S_IDLE, S_FETCH and S_DRAIN. The state is registered and always equals the access that `mem_*` presents this cycle.
- Next state:
  - S_FETCH if `w`.
  - Otherwise S_DRAIN if the FIFO is non-empty.
  - Otherwise S_IDLE.
  - Display always wins; the writer can never stall a fetch.
- S_FETCH: `mem_en=1`, `mem_we=0`, `mem_addr=disp_addr`.
  - `disp_addr` then increments, wrapping H_ACTIVE*V_ACTIVE-1 → 0.
  - If `pix_x==0 && pix_y==0`, the fetch uses address 0, `disp_addr` becomes 1, and `frame_start` pulses. This resynchronises the address every frame.
- S_DRAIN: pops the FIFO head. Drives `mem_en=1`, `mem_we=1`, `mem_addr/mem_wdata` from the head.
  - If the head address is ≥ H_ACTIVE*V_ACTIVE, the entry is popped but `mem_en=0` (write dropped).
- S_IDLE: `mem_en=0`, `mem_we=0`. `mem_addr` and `mem_wdata` hold their last values.
- FIFO:
  - `wr_ready = (fifo_level < FIFO_DEPTH)`, computed from the registered level.
  - A push occurs on `wr_valid && wr_ready`.
  - Push and pop in the same cycle leave the level unchanged.
  - When full, `wr_ready=0` even if a pop happens in the same cycle.
  - Writer must hold `wr_addr/wr_data` stable while `wr_valid && !wr_ready`.
- RGB pipeline: a fetch-valid bit follows each access.
  - In the cycle after an S_FETCH access, `RGB <= mem_rdata`.
  - After S_DRAIN or S_IDLE, `RGB <= 0`.
- Reset (asynchronous, any time, including mid-line or with the FIFO partly full):
  - Drives state S_IDLE, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `RGB=0`, `frame_start=0`.
  - Empties the FIFO: `fifo_level=0`, and `wr_ready=1` once reset is released.
  - Sets `disp_addr=0`.
  - Queued writes are lost.

## Timing
- Cycle t: `pix_x/pix_y` sampled, decision made.
- t+1: `mem_*` present the access.
- t+2: `mem_rdata` valid.
- t+3: `RGB` shows the pixel. End-to-end latency is 3 cycles, which matches the lookahead.
- Write latency: accepted at t, earliest RAM write at t+2 (`mem_*` in S_DRAIN at t+2). This holds only if `w` is 0 at t+1.
- Drain bandwidth: one entry per non-window cycle. All blanking time (160 cycles per line, 45 lines per frame) is available for draining.
- `frame_start` is asserted in the same cycle as the `mem_*` access to address 0.

## Structure
- Shared package `vga_pkg` holds:
  - H_ACTIVE, V_ACTIVE, H_TOTAL=800, V_TOTAL=525.
  - HS_START=656, HS_END=752, VS_START=490, VS_END=492.
  - FB_SIZE = H_ACTIVE*V_ACTIVE.
  - The FSM state typedef (S_IDLE/S_FETCH/S_DRAIN).
- Sub-module `vga_wr_fifo` is a synchronous FIFO with width ADDR_W+PIX_W, depth FIFO_DEPTH, and a level output. The arbiter owns the FSM, address counter and RGB pipeline.

## Test plan
- Reset mid-frame with 3 entries queued → next cycle `fifo_level=0`, `RGB=0`, `mem_en=0`; after release `wr_ready=1`. The first fetch at (0,0) gives `mem_addr=0` and `frame_start=1`.
- Full-frame sweep with a RAM model preloaded with value addr[2:0] → `RGB` at display pixel (x,y) equals (y*640+x)[2:0], 3 cycles after lookahead. `RGB=0` for x≥640 or y≥480. The address wraps to 0 after 307199.
- Write at pix_x=100, pix_y=10 (active), wr_addr=5, wr_data=3'b101 → accepted immediately. The RAM write appears at the first S_DRAIN cycle (lookahead x=640). It is not visible before then.
- Five back-to-back `wr_valid` during active video → 4 accepted, `wr_ready=0` on the 5th until the first drain cycle. Then all 5 are written in order.
- wr_addr=307200 during blanking → entry popped, `mem_en=0` that cycle, RAM unchanged.
- Fetch window reopens (x=0, next line) while the FIFO holds 2 entries → S_FETCH immediately. The remaining writes wait for the next blanking, and no fetch is skipped or delayed.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and the frame-buffer arbiter state type.
//   H_ACTIVE/V_ACTIVE : visible area
//   H_TOTAL/V_TOTAL   : full line/frame length including blanking
//   HS_*/VS_*         : sync pulse boundaries
//   FB_SIZE           : number of pixels held in the frame buffer
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned HS_START = 656;
  localparam int unsigned HS_END   = 752;
  localparam int unsigned VS_START = 490;
  localparam int unsigned VS_END   = 492;
  localparam int unsigned FB_SIZE  = H_ACTIVE * V_ACTIVE;

  // The state always names the access presented on mem_* in the same cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous write FIFO with occupancy output.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   push_i, data_i     : enqueue (ignored while full)
//   pop_i, data_o      : dequeue, data_o shows the head combinationally
//   full_o, empty_o    : status from the registered level
//   level_o            : current occupancy, 0..Depth
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module vga_wr_fifo #(
  parameter int unsigned Width = 22,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: level/pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one display read per visible pixel, writer traffic
// buffered in a FIFO and drained only in cycles with no display fetch.
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   pix_x_i, pix_y_i      : coordinates shown 3 cycles later (lookahead)
//   wr_valid_i/wr_ready_o : writer handshake, wr_addr_i = y*H_ACTIVE+x
//   mem_*_o, mem_rdata_i  : single-port RAM, read data one cycle after access
//   rgb_o                 : registered pixel, black outside fetched pixels
//   frame_start_o         : pulses with the mem_* access to address 0 at (0,0)
//   fifo_level_o          : write FIFO occupancy
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned PIX_W      = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LvlW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [9:0]        pix_x_i,
  input  logic [9:0]        pix_y_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PIX_W-1:0]  mem_wdata_o,
  input  logic [PIX_W-1:0]  mem_rdata_i,
  output logic [PIX_W-1:0]  rgb_o,
  output logic              frame_start_o,
  output logic [LvlW-1:0]   fifo_level_o
);

  import vga_pkg::*;

  localparam int unsigned FbSize = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FbSize - 1);

  arb_state_e        state_q;
  logic              mem_en_q, mem_we_q, frame_start_q, fetch_vld_q;
  logic [ADDR_W-1:0] mem_addr_q, disp_addr_q;
  logic [PIX_W-1:0]  mem_wdata_q, rgb_q;

  logic              in_window, at_origin;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [ADDR_W-1:0] head_addr;
  logic [PIX_W-1:0]  head_data;
  logic              head_in_range;

  assign in_window = (32'(pix_x_i) < H_ACTIVE) && (32'(pix_y_i) < V_ACTIVE);
  assign at_origin = (pix_x_i == '0) && (pix_y_i == '0);

  // Display always wins; the FIFO only drains outside the fetch window.
  assign fifo_pop      = !in_window && !fifo_empty;
  assign head_in_range = (32'(head_addr) < FbSize);
  assign wr_ready_o    = !fifo_full;

  vga_wr_fifo #(
    .Width (ADDR_W + PIX_W),
    .Depth (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .push_i  (wr_valid_i),
    .data_i  ({wr_addr_i, wr_data_i}),
    .pop_i   (fifo_pop),
    .data_o  ({head_addr, head_data}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      disp_addr_q   <= '0;
      frame_start_q <= 1'b0;
      fetch_vld_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      // Read data for a fetch presented last cycle is on mem_rdata_i now.
      fetch_vld_q   <= (state_q == S_FETCH);
      rgb_q         <= fetch_vld_q ? mem_rdata_i : '0;
      frame_start_q <= 1'b0;

      if (in_window) begin
        state_q  <= S_FETCH;
        mem_en_q <= 1'b1;
        mem_we_q <= 1'b0;
        if (at_origin) begin
          // Resynchronise the linear address once per frame.
          mem_addr_q    <= '0;
          disp_addr_q   <= ADDR_W'(1);
          frame_start_q <= 1'b1;
        end else begin
          mem_addr_q  <= disp_addr_q;
          disp_addr_q <= (disp_addr_q == LastAddr) ? '0 : disp_addr_q + 1'b1;
        end
      end else if (!fifo_empty) begin
        state_q     <= S_DRAIN;
        mem_en_q    <= head_in_range;  // out-of-range writes are popped and dropped
        mem_we_q    <= 1'b1;
        mem_addr_q  <= head_addr;
        mem_wdata_q <= head_data;
      end else begin
        state_q  <= S_IDLE;
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
    end
  end

  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign frame_start_o = frame_start_q;
  assign rgb_o         = rgb_q;

endmodule
